sram_rmw_wrapper: RTL and testbench

Parametrised single-port synchronous SRAM wrapper with an in-place read-modify-write (RMW) path for the FF-STDP weight memories. A weight update is a single saturating per-lane signed add issued in one request, so the learning engine does not have to sequence separate read and write cycles. A one-entry write stage keeps back-to-back read-after-write and RMW chains on the same address coherent. The memory array stays behavioural; an SRAM macro or BRAM replaces it without changing the interface.

---
 rtl/sram_rmw_wrapper.sv | 197 +++++++++++++++++++
 tb/tb_sram_rmw_wrapper.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rmw_wrapper.sv
// sram_rmw_wrapper: single-port synchronous SRAM wrapper with an in-place
// saturating read-modify-write path for the FF-STDP weight memories.
// Array writes only come from a one-entry write stage (or the clear sweep),
// which makes back-to-back read-after-write and RMW chains coherent.
// Optional feature macro: SRAM_RMW_CLEAR_EN -- when defined, every reset is
// followed by a sweep that zeroes the array before READY rises.
`timescale 1ns/1ps
module sram_rmw_wrapper #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int SRAM_DEPTH = 256,
   parameter int LANE_WIDTH = 8
) (
   input  logic                  CK,
   input  logic                  RST_N,
   input  logic                  CS,
   input  logic [1:0]            OP,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   output logic                  READY,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  QV
);

   localparam int LANES = DATA_WIDTH / LANE_WIDTH;
   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_RMW   = 2'b10;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(SRAM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [SRAM_DEPTH];

   logic                  ws_valid_q, ws_valid_d;
   logic [ADDR_WIDTH-1:0] ws_addr_q, ws_addr_d;
   logic [DATA_WIDTH-1:0] ws_data_q, ws_data_d;
   logic [DATA_WIDTH-1:0] q_q, q_d;
   logic                  qv_q, qv_d;

   logic                  ready;
   logic                  accept;
   logic                  in_range;
   logic [DATA_WIDTH-1:0] old_word;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // Per-lane signed add clamped to the lane range; lanes never carry into each other.
   // Operands are sign-extended by one bit so the sum cannot wrap, and a
   // disagreement between the top two sum bits marks overflow in that direction.
   function automatic logic [DATA_WIDTH-1:0] sat_add(
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH-1:0] r;
      logic [LANE_WIDTH:0]   s;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         s = {a[i*LANE_WIDTH+LANE_WIDTH-1], a[i*LANE_WIDTH +: LANE_WIDTH]}
           + {b[i*LANE_WIDTH+LANE_WIDTH-1], b[i*LANE_WIDTH +: LANE_WIDTH]};
         if (s[LANE_WIDTH] != s[LANE_WIDTH-1])
            r[i*LANE_WIDTH +: LANE_WIDTH] = {s[LANE_WIDTH], {(LANE_WIDTH-1){~s[LANE_WIDTH]}}};
         else
            r[i*LANE_WIDTH +: LANE_WIDTH] = s[LANE_WIDTH-1:0];
      end
      return r;
   endfunction

`ifdef SRAM_RMW_CLEAR_EN
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

   // State register: every reset restarts the sweep from address 0.
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Next-state logic: step the sweep and leave CLEAR once the last word is zeroed.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == LAST_ADDR) begin
            state_d   = ST_RUN;
            clr_cnt_d = '0;
         end
      end
   end

   // Output logic: requests are accepted only once the array is known clean.
   always_comb begin
      ready = (state_q == ST_RUN);
   end

   // Single array write port: sweep zeros during CLEAR, otherwise the write stage.
   always_comb begin
      mem_we    = ws_valid_q;
      mem_waddr = ws_addr_q;
      mem_wdata = ws_data_q;
      if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wdata = '0;
      end
   end
`else
   assign ready = 1'b1;

   // Single array write port, fed only by the write stage.
   always_comb begin
      mem_we    = ws_valid_q;
      mem_waddr = ws_addr_q;
      mem_wdata = ws_data_q;
   end
`endif

   // Current word at A: zero when out of range, pending write stage data on a hit.
   always_comb begin
      in_range = ({1'b0, A} < DEPTH_LIMIT);
      if (!in_range)
         old_word = '0;
      else if (ws_valid_q && (ws_addr_q == A))
         old_word = ws_data_q;
      else
         old_word = mem[A];
   end

   // Request decode: loads Q for reads/RMWs and the write stage for writes/RMWs.
   // Out-of-range writes never become valid, so their commit is suppressed.
   always_comb begin
      accept     = CS && ready;
      ws_valid_d = 1'b0;
      ws_addr_d  = ws_addr_q;
      ws_data_d  = ws_data_q;
      q_d        = q_q;
      qv_d       = 1'b0;
      if (accept) begin
         case (OP)
            OP_READ: begin
               q_d  = old_word;
               qv_d = 1'b1;
            end
            OP_WRITE: begin
               ws_valid_d = in_range;
               ws_addr_d  = A;
               ws_data_d  = D;
            end
            OP_RMW: begin
               q_d        = old_word;
               qv_d       = 1'b1;
               ws_valid_d = in_range;
               ws_addr_d  = A;
               ws_data_d  = sat_add(old_word, D);
            end
            default: ;
         endcase
      end
   end

   // Write stage and read-data registers; reset drops any pending write.
   always_ff @(posedge CK or negedge RST_N) begin
      if (!RST_N) begin
         ws_valid_q <= 1'b0;
         ws_addr_q  <= '0;
         ws_data_q  <= '0;
         q_q        <= '0;
         qv_q       <= 1'b0;
      end else begin
         ws_valid_q <= ws_valid_d;
         ws_addr_q  <= ws_addr_d;
         ws_data_q  <= ws_data_d;
         q_q        <= q_d;
         qv_q       <= qv_d;
      end
   end

   // Behavioural array; contents are deliberately not reset.
   always_ff @(posedge CK) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
   end

   assign READY = ready;
   assign Q     = q_q;
   assign QV    = qv_q;

endmodule

// File: tb/tb_sram_rmw_wrapper.sv
// tb_sram_rmw_wrapper: directed bench for sram_rmw_wrapper with hand-computed
// expected values. Covers reset state, read-after-write forwarding, saturating
// RMW, RMW chains, reset during a pending write and out-of-range addresses.
// Follows SRAM_RMW_CLEAR_EN the same way the design does.
`timescale 1ns/1ps
module tb_sram_rmw_wrapper;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_RMW = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

`ifdef SRAM_RMW_CLEAR_EN
   localparam logic [31:0] READY_AT_RESET = 32'd0;
   localparam logic [31:0] MEM9_AFTER_RST = 32'h0000_0000;
`else
   localparam logic [31:0] READY_AT_RESET = 32'd1;
   localparam logic [31:0] MEM9_AFTER_RST = 32'h0000_00AA;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs, cs2;
   logic [1:0]  op, op2;
   logic [7:0]  a, a2;
   logic [31:0] d, d2;
   logic        ready, ready2;
   logic [31:0] q, q2;
   logic        qv, qv2;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sram_rmw_wrapper u_dut (
      .CK(clk), .RST_N(rst_n), .CS(cs), .OP(op), .A(a), .D(d),
      .READY(ready), .Q(q), .QV(qv)
   );

   sram_rmw_wrapper #(.SRAM_DEPTH(200)) u_dut_oor (
      .CK(clk), .RST_N(rst_n), .CS(cs2), .OP(op2), .A(a2), .D(d2),
      .READY(ready2), .Q(q2), .QV(qv2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic c, input logic [1:0] o,
                                 input logic [7:0] addr, input logic [31:0] data);
      cs = c; op = o; a = addr; d = data;
      tick();
   endtask

   task automatic apply_stimulus_oor(input logic c, input logic [1:0] o,
                                     input logic [7:0] addr, input logic [31:0] data);
      cs2 = c; op2 = o; a2 = addr; d2 = data;
      tick();
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   cycles;
      logic saw_qv;

      rst_n = 1'b0;
      cs = 1'b0;  op = OP_NOP;  a = '0;  d = '0;
      cs2 = 1'b0; op2 = OP_NOP; a2 = '0; d2 = '0;
      tick();
      tick();
      check_output("reset_q", q, 32'h0);
      check_output("reset_qv", 32'(qv), 32'd0);
      check_output("reset_ready", 32'(ready), READY_AT_RESET);
      rst_n = 1'b1;

`ifdef SRAM_RMW_CLEAR_EN
      // requests during the sweep must be ignored
      cs = 1'b1; op = OP_RD; a = 8'd0;
      cycles = 0;
      saw_qv = 1'b0;
      while (ready !== 1'b1 && cycles < 1000) begin
         tick();
         cycles++;
         if (qv) saw_qv = 1'b1;
      end
      cs = 1'b0;
      check_output("clear_ready_cycles", cycles, 32'd256);
      check_output("clear_ignored_cs", 32'(saw_qv), 32'd0);
      apply_stimulus(1, OP_RD, 8'd255, 32'h0);
      check_output("clear_read255_q", q, 32'h0000_0000);
      check_output("clear_read255_qv", 32'(qv), 32'd1);
`else
      tick();
      check_output("run_ready", 32'(ready), 32'd1);
`endif

      // read-after-write, forwarded then from the array
      apply_stimulus(1, OP_WR, 8'd5, 32'h1122_3344);
      check_output("raw_write_qv", 32'(qv), 32'd0);
      check_output("raw_write_q_hold", q, 32'h0);
      apply_stimulus(1, OP_RD, 8'd5, 32'h0);
      check_output("raw_fwd_q", q, 32'h1122_3344);
      check_output("raw_fwd_qv", 32'(qv), 32'd1);
      apply_stimulus(0, OP_NOP, 8'd0, 32'h0);
      check_output("idle_qv", 32'(qv), 32'd0);
      check_output("idle_q_hold", q, 32'h1122_3344);
      apply_stimulus(0, OP_NOP, 8'd0, 32'h0);
      apply_stimulus(1, OP_RD, 8'd5, 32'h0);
      check_output("raw_array_q", q, 32'h1122_3344);

      // saturating RMW on a just-written word
      apply_stimulus(1, OP_WR, 8'd7, 32'h7F80_0102);
      apply_stimulus(1, OP_RMW, 8'd7, 32'h0180_FF01);
      check_output("sat_rmw_old_q", q, 32'h7F80_0102);
      check_output("sat_rmw_qv", 32'(qv), 32'd1);
      apply_stimulus(1, OP_RD, 8'd7, 32'h0);
      check_output("sat_fwd_q", q, 32'h7F80_0003);
      apply_stimulus(1, OP_NOP, 8'd7, 32'h0);
      check_output("cs_nop_qv", 32'(qv), 32'd0);
      apply_stimulus(1, OP_RD, 8'd7, 32'h0);
      check_output("sat_array_q", q, 32'h7F80_0003);

      // negative-side saturation and zero crossing
      apply_stimulus(1, OP_WR, 8'd8, 32'h80FF_7F00);
      apply_stimulus(0, OP_NOP, 8'd0, 32'h0);
      apply_stimulus(1, OP_RMW, 8'd8, 32'hFF01_0100);
      check_output("neg_rmw_old_q", q, 32'h80FF_7F00);
      apply_stimulus(0, OP_NOP, 8'd0, 32'h0);
      apply_stimulus(0, OP_NOP, 8'd0, 32'h0);
      apply_stimulus(1, OP_RD, 8'd8, 32'h0);
      check_output("neg_rmw_result", q, 32'h8000_7F00);

      // RMW chain on the same address every cycle
      apply_stimulus(1, OP_WR, 8'd3, 32'h0);
      apply_stimulus(1, OP_RMW, 8'd3, 32'h0101_0101);
      check_output("chain_q0", q, 32'h0000_0000);
      apply_stimulus(1, OP_RMW, 8'd3, 32'h0101_0101);
      check_output("chain_q1", q, 32'h0101_0101);
      apply_stimulus(1, OP_RMW, 8'd3, 32'h0101_0101);
      check_output("chain_q2", q, 32'h0202_0202);
      check_output("chain_q2_qv", 32'(qv), 32'd1);
      apply_stimulus(1, OP_RD, 8'd3, 32'h0);
      check_output("chain_final", q, 32'h0303_0303);

      // a write straight after an RMW on the same address wins
      apply_stimulus(1, OP_RMW, 8'd3, 32'h0101_0101);
      check_output("rmw_then_wr_q", q, 32'h0303_0303);
      apply_stimulus(1, OP_WR, 8'd3, 32'hAABB_CCDD);
      apply_stimulus(1, OP_RD, 8'd3, 32'h0);
      check_output("rmw_then_wr_read", q, 32'hAABB_CCDD);

      // reset while an RMW result sits in the write stage
      apply_stimulus(1, OP_WR, 8'd9, 32'h0000_00AA);
      apply_stimulus(0, OP_NOP, 8'd0, 32'h0);
      apply_stimulus(0, OP_NOP, 8'd0, 32'h0);
      apply_stimulus(1, OP_RMW, 8'd9, 32'h0000_0001);
      check_output("midop_rmw_q", q, 32'h0000_00AA);
      #2;
      rst_n = 1'b0;
      cs = 1'b0;
      #1;
      check_output("midop_reset_q", q, 32'h0);
      check_output("midop_reset_qv", 32'(qv), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      cycles = 0;
      while (ready !== 1'b1 && cycles < 1000) begin
         tick();
         cycles++;
      end
      check_output("midop_ready", 32'(ready), 32'd1);
      apply_stimulus(1, OP_RD, 8'd9, 32'h0);
      check_output("midop_read9", q, MEM9_AFTER_RST);
      check_output("midop_read9_qv", 32'(qv), 32'd1);
      cs = 1'b0;

      // out-of-range addresses on the 200-word instance
      cycles = 0;
      while (ready2 !== 1'b1 && cycles < 1000) begin
         tick();
         cycles++;
      end
      check_output("oor_ready", 32'(ready2), 32'd1);
      apply_stimulus_oor(1, OP_WR, 8'd199, 32'h1234_5678);
      apply_stimulus_oor(1, OP_WR, 8'd250, 32'hFFFF_FFFF);
      apply_stimulus_oor(1, OP_RD, 8'd250, 32'h0);
      check_output("oor_read_q", q2, 32'h0);
      check_output("oor_read_qv", 32'(qv2), 32'd1);
      apply_stimulus_oor(1, OP_RMW, 8'd250, 32'h0101_0101);
      check_output("oor_rmw_q", q2, 32'h0);
      check_output("oor_rmw_qv", 32'(qv2), 32'd1);
      apply_stimulus_oor(1, OP_RD, 8'd199, 32'h0);
      check_output("oor_keep199", q2, 32'h1234_5678);
      apply_stimulus_oor(0, OP_NOP, 8'd0, 32'h0);
      apply_stimulus_oor(1, OP_RD, 8'd250, 32'h0);
      check_output("oor_read_again", q2, 32'h0);
      cs2 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
